// File: rtl/mem_wb_stage.sv
// ============================================================================
// Module   : mem_wb_stage
// Purpose  : MIPS memory-access stage: data RAM, alignment check, MEM/WB reg.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mem_wb_stage #(
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  input  logic             regwriM,
  input  logic             memtoregM,
  input  logic             memwriM,
  input  logic [31:0]      aluoutM,
  input  logic [31:0]      wridataM,
  input  logic [4:0]       wriregM,
  output logic             regwriW,
  output logic             memtoregW,
  output logic [31:0]      aluoutW,
  output logic [31:0]      readdataW,
  output logic [4:0]       wriregW,
  output logic [31:0]      resultW,
  output logic             misalign_err,
  output logic [31:0]      misalign_addr,
  output logic [CNT_W-1:0] store_cnt
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [31:0]       ram_q [DEPTH];

  logic [ADDR_W-1:0] w_index;
  logic              w_misaligned;
  logic              w_commit;
  logic              w_advance;
  logic [31:0]       w_rdata;

  logic              regwri_q,    regwri_d;
  logic              memtoreg_q,  memtoreg_d;
  logic [31:0]       aluout_q,    aluout_d;
  logic [31:0]       readdata_q,  readdata_d;
  logic [4:0]        wrireg_q,    wrireg_d;
  logic              err_q,       err_d;
  logic [31:0]       erraddr_q,   erraddr_d;
  logic [CNT_W-1:0]  cnt_q,       cnt_d;

  // Upper address bits are dropped, so the RAM aliases modulo DEPTH words.
  assign w_index      = aluoutM[ADDR_W+1:2];
  assign w_misaligned = (memwriM | memtoregM) & (aluoutM[1:0] != 2'b00);
  assign w_advance    = ~stall & ~flush;
  assign w_commit     = memwriM & ~w_misaligned & w_advance & ~rst;
  assign w_rdata      = ram_q[w_index];

  always_ff @(posedge clk) begin
    if (w_commit) begin
      ram_q[w_index] <= wridataM;
    end
  end

  always_comb begin
    regwri_d   = regwri_q;
    memtoreg_d = memtoreg_q;
    aluout_d   = aluout_q;
    readdata_d = readdata_q;
    wrireg_d   = wrireg_q;
    err_d      = err_q;
    erraddr_d  = erraddr_q;
    cnt_d      = cnt_q;

    // Flush outranks stall so a simultaneous request still yields a bubble.
    if (flush) begin
      regwri_d   = 1'b0;
      memtoreg_d = 1'b0;
      aluout_d   = 32'd0;
      readdata_d = 32'd0;
      wrireg_d   = 5'd0;
    end else if (!stall) begin
      regwri_d   = regwriM & ~w_misaligned;
      memtoreg_d = memtoregM;
      aluout_d   = aluoutM;
      readdata_d = w_rdata;
      wrireg_d   = wriregM;
    end

    if (w_advance && w_misaligned && !err_q) begin
      err_d     = 1'b1;
      erraddr_d = aluoutM;
    end

    if (w_commit) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      regwri_q   <= 1'b0;
      memtoreg_q <= 1'b0;
      aluout_q   <= 32'd0;
      readdata_q <= 32'd0;
      wrireg_q   <= 5'd0;
      err_q      <= 1'b0;
      erraddr_q  <= 32'd0;
      cnt_q      <= '0;
    end else begin
      regwri_q   <= regwri_d;
      memtoreg_q <= memtoreg_d;
      aluout_q   <= aluout_d;
      readdata_q <= readdata_d;
      wrireg_q   <= wrireg_d;
      err_q      <= err_d;
      erraddr_q  <= erraddr_d;
      cnt_q      <= cnt_d;
    end
  end

  assign regwriW       = regwri_q;
  assign memtoregW     = memtoreg_q;
  assign aluoutW       = aluout_q;
  assign readdataW     = readdata_q;
  assign wriregW       = wrireg_q;
  assign resultW       = memtoreg_q ? readdata_q : aluout_q;
  assign misalign_err  = err_q;
  assign misalign_addr = erraddr_q;
  assign store_cnt     = cnt_q;

endmodule

`default_nettype wire
